// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: stalls, flushes and jump redirect
// for pc_reg, if_id and id_ex, with a BUSY watchdog and stall counter.
module pipe_ctrl #(
  parameter int BUSY_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             ex_busy_i,
  input  logic             ex_is_load_i,
  input  logic             ex_rd_wen_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             id_rs1_ren_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic             id_rs2_ren_i,
  input  logic [4:0]       id_rs2_addr_i,
  output logic             pc_jump_en_o,
  output logic [31:0]      pc_jump_addr_o,
  output logic             stall_pc_o,
  output logic             stall_if_id_o,
  output logic             stall_id_ex_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             err_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int BW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    BUSY = 2'd1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] busy_cnt;
  logic [BW-1:0] busy_nxt;
  logic          set_err;
  logic          hit;
  logic          rs1_hit;
  logic          rs2_hit;

  assign rs1_hit = id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_hit = id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i);
  assign hit     = ex_is_load_i && ex_rd_wen_i
                && (ex_rd_addr_i != 5'd0)
                && (rs1_hit || rs2_hit);

  always_comb begin
    state_nxt      = state;
    busy_nxt       = busy_cnt;
    set_err        = 1'b0;
    pc_jump_en_o   = 1'b0;
    pc_jump_addr_o = 32'd0;
    stall_pc_o     = 1'b0;
    stall_if_id_o  = 1'b0;
    stall_id_ex_o  = 1'b0;
    flush_if_id_o  = 1'b0;
    flush_id_ex_o  = 1'b0;
    // Held in reset: every control is forced low so nothing leaks out.
    if (rst) begin
      unique case (state)
        RUN: begin
          if (ex_busy_i) begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            stall_id_ex_o = 1'b1;
            state_nxt     = BUSY;
            busy_nxt      = BW'(1);
          end else if (jump_en_i) begin
            pc_jump_en_o   = 1'b1;
            pc_jump_addr_o = jump_addr_i;
            flush_if_id_o  = 1'b1;
            flush_id_ex_o  = 1'b1;
          end else if (hit) begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
          end
        end
        BUSY: begin
          if (!ex_busy_i) begin
            state_nxt = RUN;
            busy_nxt  = '0;
          end else begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            stall_id_ex_o = 1'b1;
            if (busy_cnt == BW'(BUSY_TIMEOUT - 1)) begin
              flush_id_ex_o = 1'b1;
              set_err       = 1'b1;
              state_nxt     = RUN;
              busy_nxt      = '0;
            end else begin
              busy_nxt = busy_cnt + BW'(1);
            end
          end
        end
        default: begin
          state_nxt = RUN;
          busy_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= RUN;
      busy_cnt      <= '0;
      err_timeout_o <= 1'b0;
      stall_cnt_o   <= '0;
    end else begin
      state    <= state_nxt;
      busy_cnt <= busy_nxt;
      if (set_err) begin
        err_timeout_o <= 1'b1;
      end
      if (stall_pc_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance for reset/jump/load-use/busy,
// small instance (timeout 8, 4-bit counter) for watchdog and saturation.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        ex_busy;
  logic        ex_is_load;
  logic        ex_rd_wen;
  logic [4:0]  ex_rd;
  logic        rs1_ren;
  logic [4:0]  rs1;
  logic        rs2_ren;
  logic [4:0]  rs2;

  logic        a_jen, a_spc, a_sifid, a_sidex;
  logic        a_fifid, a_fidex, a_err;
  logic [31:0] a_jaddr;
  logic [31:0] a_cnt;

  logic        b_jen, b_spc, b_sifid, b_sidex;
  logic        b_fifid, b_fidex, b_err;
  logic [31:0] b_jaddr;
  logic [3:0]  b_cnt;

  int checks;
  int failures;

  pipe_ctrl u_a (
    .clk            (clk),
    .rst            (rst),
    .jump_en_i      (jump_en),
    .jump_addr_i    (jump_addr),
    .ex_busy_i      (ex_busy),
    .ex_is_load_i   (ex_is_load),
    .ex_rd_wen_i    (ex_rd_wen),
    .ex_rd_addr_i   (ex_rd),
    .id_rs1_ren_i   (rs1_ren),
    .id_rs1_addr_i  (rs1),
    .id_rs2_ren_i   (rs2_ren),
    .id_rs2_addr_i  (rs2),
    .pc_jump_en_o   (a_jen),
    .pc_jump_addr_o (a_jaddr),
    .stall_pc_o     (a_spc),
    .stall_if_id_o  (a_sifid),
    .stall_id_ex_o  (a_sidex),
    .flush_if_id_o  (a_fifid),
    .flush_id_ex_o  (a_fidex),
    .err_timeout_o  (a_err),
    .stall_cnt_o    (a_cnt)
  );

  pipe_ctrl #(
    .BUSY_TIMEOUT (8),
    .CNT_W        (4)
  ) u_b (
    .clk            (clk),
    .rst            (rst),
    .jump_en_i      (jump_en),
    .jump_addr_i    (jump_addr),
    .ex_busy_i      (ex_busy),
    .ex_is_load_i   (ex_is_load),
    .ex_rd_wen_i    (ex_rd_wen),
    .ex_rd_addr_i   (ex_rd),
    .id_rs1_ren_i   (rs1_ren),
    .id_rs1_addr_i  (rs1),
    .id_rs2_ren_i   (rs2_ren),
    .id_rs2_addr_i  (rs2),
    .pc_jump_en_o   (b_jen),
    .pc_jump_addr_o (b_jaddr),
    .stall_pc_o     (b_spc),
    .stall_if_id_o  (b_sifid),
    .stall_id_ex_o  (b_sidex),
    .flush_if_id_o  (b_fifid),
    .flush_id_ex_o  (b_fidex),
    .err_timeout_o  (b_err),
    .stall_cnt_o    (b_cnt)
  );

  // {jump_en, stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, err}
  function automatic logic [6:0] a_ctl();
    return {a_jen, a_spc, a_sifid, a_sidex, a_fifid, a_fidex, a_err};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic set_lu(input logic ld, input logic wen, input logic [4:0] rd,
                        input logic r1e, input logic [4:0] r1,
                        input logic r2e, input logic [4:0] r2);
    ex_is_load = ld;
    ex_rd_wen  = wen;
    ex_rd      = rd;
    rs1_ren    = r1e;
    rs1        = r1;
    rs2_ren    = r2e;
    rs2        = r2;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    jump_en   = 1'b0;
    jump_addr = 32'h0;
    ex_busy   = 1'b1;
    set_lu(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);

    // Reset with busy asserted
    #3;
    check("rst_ctl", 32'(a_ctl()), 32'h0);
    repeat (2) next_cyc();
    check("rst_ctl2", 32'(a_ctl()), 32'h0);
    check("rst_cnt", a_cnt, 32'd0);
    check("rst_addr", a_jaddr, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_run_busy", 32'(a_ctl()), 32'h38);
    next_cyc();
    @(negedge clk);
    check("rel_busy", 32'(a_ctl()), 32'h38);
    check("rel_cnt", a_cnt, 32'd1);
    // Async reset mid-BUSY
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_ctl", 32'(a_ctl()), 32'h0);
    check("mid_rst_cnt", a_cnt, 32'd0);
    next_cyc();
    ex_busy = 1'b0;
    rst     = 1'b1;

    // Jump with concurrent load-use hit
    jump_en   = 1'b1;
    jump_addr = 32'h0000_0100;
    set_lu(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
    @(negedge clk);
    check("jump_ctl", 32'(a_ctl()), 32'h46);
    check("jump_addr", a_jaddr, 32'h100);
    next_cyc();

    // Load-use on rs2
    jump_en = 1'b0;
    @(negedge clk);
    check("lu_rs2_ctl", 32'(a_ctl()), 32'h32);
    check("lu_addr0", a_jaddr, 32'd0);
    next_cyc();
    set_lu(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0);
    @(negedge clk);
    check("lu_rd0", 32'(a_ctl()), 32'h0);
    next_cyc();
    set_lu(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd5);
    @(negedge clk);
    check("lu_noren", 32'(a_ctl()), 32'h0);
    next_cyc();
    set_lu(1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0);
    @(negedge clk);
    check("lu_rs1_ctl", 32'(a_ctl()), 32'h32);
    next_cyc();
    set_lu(1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0);
    @(negedge clk);
    check("lu_noload", 32'(a_ctl()), 32'h0);
    check("lu_cnt", a_cnt, 32'd2);
    next_cyc();

    // Busy for 10 cycles, jump pulse in the middle is ignored
    set_lu(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    rst_pulse();
    ex_busy = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      jump_en   = (c == 5);
      jump_addr = 32'h0000_0200;
      @(negedge clk);
      check($sformatf("busy_ctl_%0d", c), 32'(a_ctl()), 32'h38);
      check($sformatf("busy_addr_%0d", c), a_jaddr, 32'd0);
      next_cyc();
    end
    jump_en = 1'b0;
    ex_busy = 1'b0;
    @(negedge clk);
    check("busy_end_ctl", 32'(a_ctl()), 32'h0);
    check("busy_cnt", a_cnt, 32'd10);
    next_cyc();

    // Watchdog on the small instance
    rst_pulse();
    ex_busy = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      check($sformatf("wd_fidex_%0d", c), 32'(b_fidex),
            32'((c == 8) || (c == 16)));
      check($sformatf("wd_err_%0d", c), 32'(b_err), 32'(c >= 9));
      check($sformatf("wd_spc_%0d", c), 32'(b_spc), 32'd1);
      check($sformatf("wd_jen_%0d", c), 32'(b_jen), 32'd0);
      next_cyc();
    end

    // Saturating stall counter on the small instance
    rst_pulse();
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      check($sformatf("sat_cnt_%0d", c), 32'(b_cnt),
            32'((c - 1) > 15 ? 15 : (c - 1)));
      next_cyc();
    end
    ex_busy = 1'b0;
    @(negedge clk);
    check("sat_hold", 32'(b_cnt), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
